// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: repeat FSM encoding and 50 MHz timing defaults.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } rpt_state_e;

  localparam int unsigned N_CH_DEF            = 5;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;    // 10 ms at 50 MHz
  localparam int unsigned REPEAT_DELAY_DEF    = 25000000;  // 500 ms at 50 MHz
  localparam int unsigned REPEAT_RATE_DEF     = 5000000;   // 100 ms at 50 MHz

  // Larger of two cycle counts, used to size the shared repeat counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: polarity fix, 2-flop synchroniser, counter debouncer and auto-repeat FSM.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE     = REPEAT_RATE_DEF,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_in,
  input  logic repeat_en,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic level_nxt_c
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RCNT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE) + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  rpt_state_e        state_q, state_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              toggle;

  // Next-state logic: synchroniser shift, debounce counter, repeat FSM and pulse generation.
  always_comb begin
    sync1_d   = pin_in ^ ACTIVE_LOW;
    sync2_d   = sync1_q;
    cnt_d     = '0;
    level_d   = level_q;
    toggle    = 1'b0;
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        toggle  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (toggle && level_q) begin
      // Debounced release wins over any repeat pulse due this cycle.
      release_d = 1'b1;
      state_d   = ST_IDLE;
      rcnt_d    = '0;
    end else if (toggle) begin
      press_d = 1'b1;
      state_d = ST_HOLD;
      rcnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: rcnt_d = '0;
        ST_HOLD: begin
          if (!repeat_en) begin
            rcnt_d = '0;
          end else if (rcnt_q == DELAY_LAST) begin
            press_d = 1'b1;
            state_d = ST_RPT;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        ST_RPT: begin
          if (!repeat_en) begin
            // Dropping the enable re-arms the full initial delay.
            state_d = ST_HOLD;
            rcnt_d  = '0;
          end else if (rcnt_q == RATE_LAST) begin
            press_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  // State registers; reset loads the released level into the synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      state_q   <= ST_IDLE;
      rcnt_q    <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign level_nxt_c = level_d;

endmodule

// File: rtl/button_conditioner.sv
// N-channel push-button front end: per-channel conditioning plus a registered any-pressed flag.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned      N_CH            = N_CH_DEF,
  parameter int unsigned      DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned      REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned      REPEAT_RATE     = REPEAT_RATE_DEF,
  parameter logic [N_CH-1:0]  ACTIVE_LOW      = {N_CH{1'b1}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic            btn_any
);

  logic [N_CH-1:0] level_nxt;
  logic            btn_any_q, btn_any_d;

  // Independent channels; no arbitration between simultaneous presses.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .ACTIVE_LOW      (ACTIVE_LOW[i])
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .pin_in      (btn_in[i]),
      .repeat_en   (repeat_en[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .level_nxt_c (level_nxt[i])
    );
  end

  // Any-pressed flag built from next levels so it changes in step with btn_level.
  always_comb begin
    btn_any_d = |level_nxt;
  end

  // Any-pressed register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_any_q <= 1'b0;
    end else begin
      btn_any_q <= btn_any_d;
    end
  end

  assign btn_any = btn_any_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner against a window/anchor-based behavioural model.
module tb_button_conditioner;

  localparam int        DEB   = 4;
  localparam int        DELAY = 10;
  localparam int        RATE  = 3;
  localparam logic [1:0] AL   = 2'b01;

  logic       clk;
  logic       rst;
  logic [1:0] btn_in;
  logic [1:0] repeat_en;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic       btn_any;

  button_conditioner #(
    .N_CH            (2),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (DELAY),
    .REPEAT_RATE     (RATE),
    .ACTIVE_LOW      (AL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .repeat_en   (repeat_en),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_any     (btn_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int e        = 0;

  // Reference model: pin delay line, sliding window of synchronised samples, repeat anchor.
  bit         pd    [2][2];
  bit         win   [2][DEB];
  int         nwin  [2];
  int         anchor[2];
  logic [1:0] m_level;
  logic [1:0] exp_press;
  logic [1:0] exp_rel;

  int plog0[$];
  int plog1[$];
  int rlog0[$];
  int rlog1[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, e, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      pd[c][0] = 1'b0;
      pd[c][1] = 1'b0;
      for (int k = 0; k < DEB; k++) win[c][k] = 1'b0;
      nwin[c]   = 0;
      anchor[c] = 0;
    end
    m_level   = 2'b00;
    exp_press = 2'b00;
    exp_rel   = 2'b00;
  endtask

  // Level flips once the last DEB synchronised samples since the previous flip all disagree with it.
  // While held, repeat pulses fall at DELAY, DELAY+RATE, ... enabled edges after the anchor.
  task automatic model_step(input logic [1:0] pr, input logic [1:0] en);
    for (int c = 0; c < 2; c++) begin
      bit s;
      bit all_mis;
      int m;
      s        = pd[c][0];
      pd[c][0] = pd[c][1];
      pd[c][1] = pr[c];
      for (int k = 0; k < DEB - 1; k++) win[c][k] = win[c][k+1];
      win[c][DEB-1] = s;
      nwin[c]++;
      all_mis = 1'b1;
      for (int k = 0; k < DEB; k++) if (win[c][k] == m_level[c]) all_mis = 1'b0;
      exp_press[c] = 1'b0;
      exp_rel[c]   = 1'b0;
      if (nwin[c] >= DEB && all_mis) begin
        m_level[c] = ~m_level[c];
        nwin[c]    = 0;
        if (m_level[c]) begin
          exp_press[c] = 1'b1;
          anchor[c]    = e;
        end else begin
          exp_rel[c] = 1'b1;
        end
      end else if (m_level[c]) begin
        if (!en[c]) begin
          anchor[c] = e;
        end else begin
          m = e - anchor[c];
          if (m == DELAY || (m > DELAY && (m - DELAY) % RATE == 0)) exp_press[c] = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive pressed-state and enables, advance model, compare just after the edge.
  task automatic tick(input logic [1:0] pr, input logic [1:0] en);
    btn_in    = pr ^ AL;
    repeat_en = en;
    @(posedge clk);
    e++;
    model_step(pr, en);
    #1;
    check_eq("level",   32'(btn_level),   32'(m_level));
    check_eq("press",   32'(btn_press),   32'(exp_press));
    check_eq("release", 32'(btn_release), 32'(exp_rel));
    check_eq("any",     32'(btn_any),     32'(|m_level));
    check_eq("press_and_release", 32'(btn_press & btn_release), 32'd0);
    if (btn_press[0])   plog0.push_back(e);
    if (btn_press[1])   plog1.push_back(e);
    if (btn_release[0]) rlog0.push_back(e);
    if (btn_release[1]) rlog1.push_back(e);
  endtask

  task automatic clear_logs();
    plog0.delete();
    plog1.delete();
    rlog0.delete();
    rlog1.delete();
  endtask

  // Async reset away from the clock edge; outputs must clear before any edge.
  task automatic do_reset();
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst_level",   32'(btn_level),   32'd0);
    check_eq("rst_press",   32'(btn_press),   32'd0);
    check_eq("rst_release", 32'(btn_release), 32'd0);
    check_eq("rst_any",     32'(btn_any),     32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int         t0;
    int         run[2];
    logic [1:0] pr;
    logic [1:0] en;

    rst       = 1'b1;
    btn_in    = AL;
    repeat_en = 2'b00;
    model_reset();
    do_reset();
    for (int i = 0; i < 5; i++) tick(2'b00, 2'b00);

    // Clean press on ch1, no repeat.
    clear_logs();
    t0 = e;
    for (int i = 0; i < 20; i++) tick(2'b10, 2'b00);
    check_eq("clean_press_count", 32'(plog1.size()), 32'd1);
    if (plog1.size() > 0) check_eq("clean_press_edge", 32'(plog1[0] - t0), 32'(2 + DEB));
    for (int i = 0; i < 10; i++) tick(2'b00, 2'b00);
    check_eq("clean_release_count", 32'(rlog1.size()), 32'd1);

    // Bounce on ch0: pressed 3, released 1, then held.
    clear_logs();
    for (int i = 0; i < 3; i++) tick(2'b01, 2'b00);
    tick(2'b00, 2'b00);
    t0 = e;
    for (int i = 0; i < 15; i++) tick(2'b01, 2'b00);
    check_eq("bounce_press_count", 32'(plog0.size()), 32'd1);
    if (plog0.size() > 0) check_eq("bounce_press_edge", 32'(plog0[0] - t0), 32'(2 + DEB));
    for (int i = 0; i < 10; i++) tick(2'b00, 2'b00);

    // Auto-repeat on ch1, released so the debounced release lands at +20.
    clear_logs();
    t0 = e;
    for (int i = 0; i < 14; i++) tick(2'b10, 2'b10);
    for (int i = 0; i < 16; i++) tick(2'b00, 2'b10);
    check_eq("rpt_count", 32'(plog1.size()), 32'd3);
    if (plog1.size() == 3) begin
      check_eq("rpt_first",  32'(plog1[0] - t0), 32'd6);
      check_eq("rpt_second", 32'(plog1[1] - t0), 32'd16);
      check_eq("rpt_third",  32'(plog1[2] - t0), 32'd19);
    end
    check_eq("rpt_release_count", 32'(rlog1.size()), 32'd1);
    if (rlog1.size() > 0) check_eq("rpt_release_edge", 32'(rlog1[0] - t0), 32'd20);

    // repeat_en dropped in RPT, then raised again.
    clear_logs();
    t0 = e;
    for (int i = 0; i < 17; i++) tick(2'b10, 2'b10);
    for (int i = 0; i < 7; i++)  tick(2'b10, 2'b00);
    for (int i = 0; i < 16; i++) tick(2'b10, 2'b10);
    check_eq("reen_count", 32'(plog1.size()), 32'd5);
    if (plog1.size() == 5) begin
      check_eq("reen_resume", 32'(plog1[2] - (t0 + 24)), 32'(DELAY));
      check_eq("reen_next",   32'(plog1[3] - plog1[2]),  32'(RATE));
    end
    for (int i = 0; i < 10; i++) tick(2'b00, 2'b00);

    // Simultaneous press on both channels, then release only ch0.
    clear_logs();
    t0 = e;
    for (int i = 0; i < 12; i++) tick(2'b11, 2'b00);
    check_eq("both_cnt0", 32'(plog0.size()), 32'd1);
    check_eq("both_cnt1", 32'(plog1.size()), 32'd1);
    if (plog0.size() > 0 && plog1.size() > 0) begin
      check_eq("both_same_edge", 32'(plog0[0]), 32'(plog1[0]));
      check_eq("both_edge",      32'(plog0[0] - t0), 32'(2 + DEB));
    end
    check_eq("both_any", 32'(btn_any), 32'd1);
    for (int i = 0; i < 10; i++) tick(2'b10, 2'b00);
    check_eq("one_left_any",   32'(btn_any),   32'd1);
    check_eq("one_left_level", 32'(btn_level), 32'd2);

    // Reset while ch1 is held; outputs stay quiet afterwards with pins released.
    do_reset();
    for (int i = 0; i < 8; i++) tick(2'b00, 2'b00);

    // Randomised pins (mix of bounces and long holds), enables and occasional resets.
    run[0] = 0;
    run[1] = 0;
    pr     = 2'b00;
    en     = 2'b11;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (run[c] == 0) begin
          pr[c]  = ~pr[c];
          run[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                : int'($urandom_range(4, 40));
        end
        run[c]--;
      end
      if ($urandom_range(0, 29) == 0) en = en ^ 2'($urandom_range(1, 3));
      tick(pr, en);
      if (i == 700 || i == 1400) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
